// File: rtl/temp_a_ctrl.sv
// temp_a_ctrl: sequencing controller for the Temp_A coefficient staging buffer.
// One frame is a fill of 2*DEPTH words alternating between half 0 and half 1,
// then DEPTH consumer pops at the selected coefficient width, then DEPTH
// discard pops of the unused-width FIFO pair. After the flush, both pairs are
// empty for the next frame.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset (also the FIFOs' srst)
//   start, mode       begin a frame (sampled only in IDLE); width select latched at start
//   in_valid/in_ready upstream word handshake (in_ready = controller in FILL)
//   out_ready         consumer permits a pop this cycle
//   t_wr_flag/t_wr_half  buffer write strobe and half select (same cycle as in_valid)
//   t_rd_flag/t_choose   buffer read strobe and width select
//   out_valid         buffer dout_1..dout_4 hold a valid quad (one cycle after the pop)
//   busy, done        frame in progress; one-cycle end-of-frame pulse
module temp_a_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CW    = $clog2(2 * DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mode,
    input  logic in_valid,
    output logic in_ready,
    input  logic out_ready,
    output logic t_wr_flag,
    output logic t_wr_half,
    output logic t_rd_flag,
    output logic t_choose,
    output logic out_valid,
    output logic busy,
    output logic done
);

    localparam logic [CW-1:0] WR_LAST = CW'(2 * DEPTH - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_DRAIN = 3'd2,
        S_FLUSH = 3'd3,
        S_FIN   = 3'd4
    } state_e;

    state_e        state_q,     state_d;
    logic [CW-1:0] wr_cnt_q,    wr_cnt_d;
    logic [CW-1:0] rd_cnt_q,    rd_cnt_d;
    logic          mode_q,      mode_d;
    // Set once the flush idle cycle has elapsed, so the last drain quad is
    // presented while t_choose still selects the drained width.
    logic          flush_go_q,  flush_go_d;
    logic          out_valid_q, out_valid_d;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            mode_q      <= 1'b0;
            flush_go_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            mode_q      <= mode_d;
            flush_go_q  <= flush_go_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        mode_d      = mode_q;
        flush_go_d  = flush_go_q;
        out_valid_d = 1'b0;
        in_ready    = 1'b0;
        t_wr_flag   = 1'b0;
        t_wr_half   = 1'b0;
        t_rd_flag   = 1'b0;
        t_choose    = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    state_d  = S_FILL;
                end
            end

            S_FILL: begin
                in_ready  = 1'b1;
                t_choose  = mode_q;
                t_wr_flag = in_valid;
                t_wr_half = wr_cnt_q[0];
                if (in_valid) begin
                    if (wr_cnt_q == WR_LAST) begin
                        wr_cnt_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
            end

            S_DRAIN: begin
                t_choose    = mode_q;
                t_rd_flag   = out_ready && (rd_cnt_q <= RD_LAST);
                out_valid_d = t_rd_flag;
                if (t_rd_flag) begin
                    if (rd_cnt_q == RD_LAST) begin
                        rd_cnt_d   = '0;
                        flush_go_d = 1'b0;
                        state_d    = S_FLUSH;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
            end

            S_FLUSH: begin
                if (!flush_go_q) begin
                    t_choose   = mode_q;
                    flush_go_d = 1'b1;
                end else begin
                    t_choose  = ~mode_q;
                    t_rd_flag = 1'b1;
                    if (rd_cnt_q == RD_LAST) begin
                        rd_cnt_d = '0;
                        state_d  = S_FIN;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
            end

            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_temp_a_ctrl.sv
// Scoreboard bench for temp_a_ctrl: the stimulus pushes expected strobe events
// (kind, value, cycle) into a queue, and a negedge monitor pops and compares
// every event the DUT presents.
module tb_temp_a_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(2 * DEPTH) + 1;

    localparam int EV_WR   = 0;
    localparam int EV_OV   = 1;
    localparam int EV_RD   = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int   kind;
        logic val;
        int   cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst, start, mode, in_valid, out_ready;
    logic in_ready, t_wr_flag, t_wr_half, t_rd_flag, t_choose, out_valid, busy, done;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    ev_t exp_q[$];

    temp_a_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .t_wr_flag (t_wr_flag),
        .t_wr_half (t_wr_half),
        .t_rd_flag (t_rd_flag),
        .t_choose  (t_choose),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int kind, input logic val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input logic val);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d val %0b at cycle %0d, expected none", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                n_err++;
                $display("FAIL event: got kind %0d val %0b cycle %0d expected kind %0d val %0b cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: fixed per-cycle order WR, OV, RD, DONE matches the push order.
    always @(negedge clk) begin
        if (t_wr_flag) expect_ev(EV_WR, t_wr_half);
        if (out_valid) expect_ev(EV_OV, t_choose);
        if (t_rd_flag) expect_ev(EV_RD, t_choose);
        if (done)      expect_ev(EV_DONE, 1'b0);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missed_event: kind %0d val %0b due cycle %0d not seen by cycle %0d",
                     exp_q[0].kind, exp_q[0].val, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame; abort_pops >= 0 asserts rst after that many drain pops.
    task automatic run_frame(input logic m, input bit gap, input logic [15:0] orp,
                             input int orn, input int abort_pops, input bit poke);
        int acc, pops, j, k;
        start = 1'b1; mode = m; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("idle_in_ready", 32'(in_ready), 32'd0);
        step();
        start = 1'b0; mode = ~m;
        acc = 0; k = 0;
        while (acc < 2 * DEPTH) begin
            in_valid = gap ? (k % 2 == 0) : 1'b1;
            start    = poke && (k == 1);
            if (k == 0) begin
                #1;
                chk("fill_in_ready", 32'(in_ready), 32'd1);
                chk("fill_busy", 32'(busy), 32'd1);
            end
            if (in_valid) begin
                push(EV_WR, 1'(acc % 2), cyc);
                acc++;
            end
            k++;
            step();
        end
        in_valid = 1'b1; start = 1'b0;
        pops = 0; j = 0;
        while (pops < DEPTH) begin
            out_ready = (j < orn) ? orp[j] : 1'b1;
            if (out_ready) begin
                push(EV_RD, m, cyc);
                push(EV_OV, m, cyc + 1);
                pops++;
            end
            j++;
            step();
            if (pops == abort_pops) begin
                rst = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
                step();
                rst = 1'b0;
                #1;
                chk("rst_in_ready", 32'(in_ready), 32'd0);
                chk("rst_wr_flag", 32'(t_wr_flag), 32'd0);
                chk("rst_rd_flag", 32'(t_rd_flag), 32'd0);
                chk("rst_choose", 32'(t_choose), 32'd0);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                return;
            end
        end
        // Flush: out_ready low to show it is ignored; start pulse must be ignored.
        out_ready = 1'b0; start = poke;
        step();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push(EV_RD, ~m, cyc);
            step();
        end
        push(EV_DONE, 1'b0, cyc);
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        #1 chk("post_frame_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_wr_flag", 32'(t_wr_flag), 32'd0);
        chk("reset_wr_half", 32'(t_wr_half), 32'd0);
        chk("reset_rd_flag", 32'(t_rd_flag), 32'd0);
        chk("reset_choose", 32'(t_choose), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        step();

        run_frame(1'b0, 1'b0, 16'h0000, 0, -1, 1'b1);  // basic 24-bit, start pokes
        run_frame(1'b1, 1'b0, 16'h0000, 0, -1, 1'b0);  // 25-bit
        run_frame(1'b0, 1'b0, 16'h0059, 7, -1, 1'b0);  // backpressure 1,0,0,1,1,0,1
        run_frame(1'b1, 1'b1, 16'h0000, 0, -1, 1'b1);  // gapped input
        run_frame(1'b1, 1'b0, 16'h0000, 0, 2, 1'b0);   // reset after 2 pops
        run_frame(1'b1, 1'b0, 16'h0000, 0, -1, 1'b0);  // clean frame after reset

        step(); step(); step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
